// File: rtl/morse_char_detect.sv
// ============================================================================
// Module   : morse_char_detect
// Purpose  : Recognises one target Morse character on a raw 1-bit line by
//            classifying mark run lengths and matching them symbol by symbol.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_char_detect #(
    parameter int MAX_SYMS = 8,
    parameter int CNT_W    = 4,
    parameter int DOT_MAX  = 2,
    parameter int DASH_MIN = 3,
    parameter int DASH_MAX = 6,
    parameter int CHAR_GAP = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in,
    input  logic [MAX_SYMS-1:0]              pattern,
    input  logic [$clog2(MAX_SYMS+1)-1:0]    pat_len,
    output logic                             cb,
    output logic                             is,
    output logic [$clog2(MAX_SYMS+1)-1:0]    sym_cnt
);

    localparam int               c_SW       = $clog2(MAX_SYMS + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_DOT_MAX  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] c_DASH_MIN = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] c_DASH_MAX = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] c_CHAR_GAP = CNT_W'(CHAR_GAP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MARK = 2'd1,
        S_GAP  = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [c_SW-1:0]     r_sym_cnt, w_sym_nxt;
    logic [MAX_SYMS-1:0] r_pat, w_pat_nxt;
    logic [c_SW-1:0]     r_len, w_len_nxt;
    logic                r_cb, r_is, w_is_nxt, w_cb_nxt;

    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_is_dot, w_is_dash, w_exp_sym, w_sym_ok;

    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_is_dot  = (r_cnt <= c_DOT_MAX);
    assign w_is_dash = (r_cnt >= c_DASH_MIN) && (r_cnt <= c_DASH_MAX);

    always_comb begin
        w_exp_sym = 1'b0;
        for (int i = 0; i < MAX_SYMS; i++) begin
            if (r_sym_cnt == c_SW'(i)) w_exp_sym = r_pat[i];
        end
    end

    assign w_sym_ok = (w_is_dot || w_is_dash) && (r_sym_cnt < r_len) &&
                      (w_exp_sym == w_is_dash);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sym_nxt   = r_sym_cnt;
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_is_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sym_nxt = '0;
                w_cnt_nxt = '0;
                if (in) begin
                    w_state_nxt = S_MARK;
                    w_cnt_nxt   = CNT_W'(1);
                    w_pat_nxt   = pattern;
                    w_len_nxt   = pat_len;
                end
            end
            S_MARK: begin
                if (in) begin
                    if (w_cnt_inc > c_DASH_MAX) begin
                        w_state_nxt = S_FAIL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    // The falling-edge low sample is the first zero of the following gap.
                    w_cnt_nxt = CNT_W'(1);
                    if (w_sym_ok) begin
                        w_state_nxt = S_GAP;
                        w_sym_nxt   = r_sym_cnt + c_SW'(1);
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end
            end
            S_GAP: begin
                if (in) begin
                    w_state_nxt = S_MARK;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_CHAR_GAP) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        // A recognised character keeps its count visible alongside the pulse.
                        if (r_sym_cnt == r_len) w_is_nxt = 1'b1;
                        else                    w_sym_nxt = '0;
                    end
                end
            end
            S_FAIL: begin
                if (in) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_CHAR_GAP) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_sym_nxt   = '0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_cb_nxt = (w_state_nxt == S_MARK) || (w_state_nxt == S_GAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sym_cnt <= '0;
            r_pat     <= '0;
            r_len     <= '0;
            r_cb      <= 1'b0;
            r_is      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sym_cnt <= w_sym_nxt;
            r_pat     <= w_pat_nxt;
            r_len     <= w_len_nxt;
            r_cb      <= w_cb_nxt;
            r_is      <= w_is_nxt;
        end
    end

    assign cb      = r_cb;
    assign is      = r_is;
    assign sym_cnt = r_sym_cnt;

endmodule

`default_nettype wire
